decoder_2_4_hold_v: RTL and testbench

Sequential 2-to-4 line decoder, the counterpart of the team's 4:2 priority encoder. It accepts a 2-bit code through a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. It then releases the line and signals completion. Line numbering matches the encoder (line 0 = code 2'b00), so re-encoding `o_line` always returns the accepted code.

---
 rtl/dec_pkg.sv | 29 ++
 rtl/hold_timer_v.sv | 28 ++
 rtl/decoder_2_4_hold_v.sv | 122 ++++++++++++
 tb/tb_decoder_2_4_hold_v.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared definitions for the 2-to-4 hold decoder: widths, state encoding,
// default hold length and the line decode/encode helpers.
package dec_pkg;

  localparam int unsigned CODE_W          = 2;
  localparam int unsigned LINE_W          = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Code to one-hot line; line 0 corresponds to code 2'b00.
  function automatic logic [LINE_W-1:0] dec_line(input logic [CODE_W-1:0] code);
    return LINE_W'(1) << code;
  endfunction

  // Line back to code, line 0 has the highest priority.
  function automatic logic [CODE_W-1:0] enc_line(input logic [LINE_W-1:0] line);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = LINE_W - 1; i >= 0; i--) begin
      if (line[i]) code = CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/hold_timer_v.sv
// Loadable down-counter that tells the decoder FSM when a hold has expired.
module hold_timer_v #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_2_4_hold_v.sv
// Sequential 2-to-4 decoder: accepts a code over valid/ready, holds the
// one-hot line for HOLD_CYCLES cycles, then pulses o_done.
// Optional round-trip self-check enabled by macro DEC_ROUNDTRIP_CHECK_EN.
module decoder_2_4_hold_v
  import dec_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [CODE_W-1:0] i_code,
  output logic              o_ready,
  output logic [LINE_W-1:0] o_line,
  output logic              o_active,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [LINE_W-1:0] line_d;
  logic              ready_d, active_d, done_d;
  logic              tmr_load, tmr_dec, tmr_zero;

  hold_timer_v #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (tmr_dec),
    .o_zero     (tmr_zero)
  );

  // State and registered outputs; reset drops the line without a done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      o_line   <= '0;
      o_ready  <= 1'b1;
      o_active <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      o_line   <= line_d;
      o_ready  <= ready_d;
      o_active <= active_d;
      o_done   <= done_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    line_d   = o_line;
    ready_d  = o_ready;
    active_d = o_active;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        line_d   = '0;
        active_d = 1'b0;
        ready_d  = 1'b1;
        if (i_valid && o_ready) begin
          code_d   = i_code;
          line_d   = dec_line(i_code);
          active_d = 1'b1;
          ready_d  = 1'b0;
          tmr_load = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        line_d   = dec_line(code_q);
        active_d = 1'b1;
        ready_d  = 1'b0;
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          line_d   = '0;
          active_d = 1'b0;
          ready_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef DEC_ROUNDTRIP_CHECK_EN
  logic line_onehot;
  logic line_bad;

  assign line_onehot = (o_line != '0) && ((o_line & (o_line - LINE_W'(1))) == '0);
  assign line_bad    = o_active && (!line_onehot || (enc_line(o_line) != code_q));

  // Sticky error whenever the held line fails to re-encode to the latched code.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (line_bad) begin
      o_err <= 1'b1;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_2_4_hold_v.sv
// Self-checking bench for decoder_2_4_hold_v: a per-cycle vector table on a
// HOLD_CYCLES=4 instance plus hand sequences for reset mid-hold, the
// HOLD_CYCLES=1 boundary and the round-trip error flag.
module tb_decoder_2_4_hold_v;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [1:0] code;

  logic       ready4, active4, done4, err4;
  logic [3:0] line4;
  logic       ready1, active1, done1, err1;
  logic [3:0] line1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  decoder_2_4_hold_v #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_code(code),
    .o_ready(ready4), .o_line(line4), .o_active(active4),
    .o_done(done4), .o_err(err4)
  );

  decoder_2_4_hold_v #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_code(code),
    .o_ready(ready1), .o_line(line1), .o_active(active1),
    .o_done(done1), .o_err(err1)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [1:0] code;
    logic [3:0] line;
    logic       ready;
    logic       done;
    logic       active;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic v, input logic [1:0] c,
                              input logic [3:0] l, input logic rdy,
                              input logic d, input logic a);
    vec_t x;
    x.rst = r; x.valid = v; x.code = c;
    x.line = l; x.ready = rdy; x.done = d; x.active = a;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] lk;
    logic       nv;
    logic [1:0] nc;

    rst = 1'b1; valid = 1'b0; code = 2'b00;

    // Reset with a pending request: nothing may be accepted.
    add(1, 1, 2'b10, 4'b0000, 1, 0, 0);
    add(1, 1, 2'b10, 4'b0000, 1, 0, 0);
    add(0, 0, 2'b00, 4'b0000, 1, 0, 0);
    // Single decode of code 3.
    add(0, 1, 2'b11, 4'b1000, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 2'b00, 4'b1000, 0, 0, 1);
    add(0, 0, 2'b00, 4'b0000, 1, 1, 0);
    add(0, 0, 2'b00, 4'b0000, 1, 0, 0);
    // All codes back to back, valid held high with the next code during hold.
    for (int k = 0; k < 4; k++) begin
      lk = 4'b0001 << k;
      nv = (k < 3);
      nc = 2'(k + 1);
      add(0, 1, 2'(k), lk, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(0, nv, nc, lk, 0, 0, 1);
      add(0, nv, nc, 4'b0000, 1, 1, 0);
    end
    add(0, 0, 2'b00, 4'b0000, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; valid = vecs[i].valid; code = vecs[i].code;
      tick();
      chk($sformatf("v%0d line", i),   line4,          vecs[i].line);
      chk($sformatf("v%0d ready", i),  {3'b0, ready4}, {3'b0, vecs[i].ready});
      chk($sformatf("v%0d done", i),   {3'b0, done4},  {3'b0, vecs[i].done});
      chk($sformatf("v%0d active", i), {3'b0, active4},{3'b0, vecs[i].active});
      chk($sformatf("v%0d err", i),    {3'b0, err4},   4'b0000);
    end

    // Reset during the second hold edge: line drops, no done pulse.
    valid = 1'b1; code = 2'b10; tick();
    chk("mid accept line", line4, 4'b0100);
    valid = 1'b0; rst = 1'b1; tick();
    chk("mid rst line",  line4, 4'b0000);
    chk("mid rst ready", {3'b0, ready4}, 4'b0001);
    chk("mid rst done",  {3'b0, done4},  4'b0000);
    rst = 1'b0; tick();
    chk("mid post done", {3'b0, done4}, 4'b0000);
    chk("mid post line", line4, 4'b0000);
    valid = 1'b1; code = 2'b01; tick();
    chk("mid re-accept line",  line4, 4'b0010);
    chk("mid re-accept ready", {3'b0, ready4}, 4'b0000);
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid hold%0d line", i), line4, 4'b0010);
    end
    tick();
    chk("mid end done", {3'b0, done4}, 4'b0001);
    chk("mid end line", line4, 4'b0000);

    // HOLD_CYCLES=1: one-cycle pulse, accept every second edge.
    rst = 1'b1; tick();
    chk("h1 rst ready", {3'b0, ready1}, 4'b0001);
    rst = 1'b0; valid = 1'b1; code = 2'b01;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk($sformatf("h1 acc%0d line", r),  line1, 4'b0010);
      chk($sformatf("h1 acc%0d ready", r), {3'b0, ready1}, 4'b0000);
      chk($sformatf("h1 acc%0d done", r),  {3'b0, done1},  4'b0000);
      chk($sformatf("h1 acc%0d act", r),   {3'b0, active1},4'b0001);
      tick();
      chk($sformatf("h1 end%0d line", r),  line1, 4'b0000);
      chk($sformatf("h1 end%0d ready", r), {3'b0, ready1}, 4'b0001);
      chk($sformatf("h1 end%0d done", r),  {3'b0, done1},  4'b0001);
    end
    valid = 1'b0; tick();
    chk("h1 idle done", {3'b0, done1}, 4'b0000);
    chk("h1 idle line", line1, 4'b0000);
    chk("h1 err", {3'b0, err1}, 4'b0000);

    // Round-trip error flag.
    rst = 1'b1; tick();
    rst = 1'b0; valid = 1'b1; code = 2'b10; tick();
    valid = 1'b0;
    chk("err before", {3'b0, err4}, 4'b0000);
`ifdef DEC_ROUNDTRIP_CHECK_EN
    force dut.o_line = 4'b0110;
    tick();
    chk("err set", {3'b0, err4}, 4'b0001);
    release dut.o_line;
    tick();
    chk("err sticky", {3'b0, err4}, 4'b0001);
    for (int i = 0; i < 4; i++) tick();
    chk("err sticky idle", {3'b0, err4}, 4'b0001);
    rst = 1'b1; tick();
    chk("err cleared", {3'b0, err4}, 4'b0000);
    rst = 1'b0;
`else
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("err tied%0d", i), {3'b0, err4}, 4'b0000);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
